mem_access_ctrl: RTL

//  Sequences data-memory loads/stores from the single-cycle core onto a valid/ready memory bus.

---
 rtl/mem_access_ctrl_pkg.sv | 25 ++
 rtl/mem_access_ctrl_lane_align.sv | 70 +++++++
 rtl/mem_access_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the data-memory access controller: FSM states, access-size codes
// and the latched request record.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } mem_ctrl_state_t;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  // Snapshot of the core's request, taken in IDLE so the bus sees stable values.
  typedef struct packed {
    logic        r_w;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Combinational lane steering: byte enables, store replication and load extraction/extension.
// MISALIGN_TRAP_EN: when defined, flags misaligned half/word/size-3 accesses.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        load_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_val = rdata[15:8];
      2'd2:    byte_val = rdata[23:16];
      2'd3:    byte_val = rdata[31:24];
      default: byte_val = rdata[7:0];
    endcase
    // Halves only look at addr[1]; a stray addr[0] is forced aligned.
    half_val = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be        = 4'hF;
    wdata     = store_data;
    load_data = rdata;
    case (size)
      MEM_SIZE_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = load_unsigned ? {24'd0, byte_val} : {{24{byte_val[7]}}, byte_val};
      end
      MEM_SIZE_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = load_unsigned ? {16'd0, half_val} : {{16{half_val[15]}}, half_val};
      end
      default: begin
        // Word and the reserved size both use the full lane-0 word.
        be        = 4'hF;
        wdata     = store_data;
        load_data = rdata;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    case (size)
      MEM_SIZE_HALF: misaligned = addr_lo[0];
      MEM_SIZE_WORD: misaligned = (addr_lo != 2'b00);
      2'd3:          misaligned = 1'b1;
      default:       misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences core loads/stores onto a valid/ready memory bus and stalls the PC until done.
// MISALIGN_TRAP_EN: when defined, misaligned accesses complete immediately with bus_err.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        core_req,
  input  logic        mem_r_w,
  input  logic [1:0]  mem_access_size,
  input  logic        mem_load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        bus_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata
);

  localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  mem_ctrl_state_t   state_reg;
  mem_req_t          req_reg;
  mem_req_t          live_req;
  logic [CNT_W-1:0]  timeout_cnt_reg;
  logic [31:0]       load_data_reg;
  logic              bus_err_reg;

  logic [1:0]  sel_size;
  logic [1:0]  sel_addr_lo;
  logic        sel_unsigned;
  logic [31:0] sel_wdata;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic [31:0] align_load;
  logic        misaligned;

  always_comb begin
    live_req               = '0;
    live_req.r_w           = mem_r_w;
    live_req.size          = mem_access_size;
    live_req.load_unsigned = mem_load_unsigned;
    live_req.addr          = addr;
    live_req.wdata         = store_data;
  end

  // The aligner sees the live request in IDLE (for the misalign decision) and the
  // latched one afterwards (for bus lanes and load extraction).
  always_comb begin
    if (state_reg == IDLE) begin
      sel_size     = live_req.size;
      sel_addr_lo  = live_req.addr[1:0];
      sel_unsigned = live_req.load_unsigned;
      sel_wdata    = live_req.wdata;
    end else begin
      sel_size     = req_reg.size;
      sel_addr_lo  = req_reg.addr[1:0];
      sel_unsigned = req_reg.load_unsigned;
      sel_wdata    = req_reg.wdata;
    end
  end

  mem_lane_align u_lane_align (
    .size          (sel_size),
    .addr_lo       (sel_addr_lo),
    .load_unsigned (sel_unsigned),
    .store_data    (sel_wdata),
    .rdata         (bus_rsp_rdata),
    .be            (align_be),
    .wdata         (align_wdata),
    .load_data     (align_load),
    .misaligned    (misaligned)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= IDLE;
      req_reg         <= '0;
      timeout_cnt_reg <= '0;
      load_data_reg   <= '0;
      bus_err_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (core_req) begin
            req_reg       <= live_req;
            load_data_reg <= '0;
            if (misaligned) begin
              bus_err_reg <= 1'b1;
              state_reg   <= DONE;
            end else begin
              bus_err_reg <= 1'b0;
              state_reg   <= REQ;
            end
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            timeout_cnt_reg <= '0;
            state_reg       <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (bus_rsp_valid) begin
            load_data_reg <= req_reg.r_w ? align_load : 32'd0;
            state_reg     <= DONE;
          end else if (TIMEOUT_CYCLES > 0) begin
            if (timeout_cnt_reg == CNT_W'(TO_LAST)) begin
              bus_err_reg <= 1'b1;
              state_reg   <= DONE;
            end else begin
              timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
            end
          end
        end
        DONE: begin
          bus_err_reg <= 1'b0;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs decode the state register; reset forces them low in the same cycle.
  logic in_req;
  assign in_req        = !reset && (state_reg == REQ);
  assign bus_req_valid = in_req;
  assign bus_we        = in_req && !req_reg.r_w;
  assign bus_addr      = in_req ? {req_reg.addr[31:2], 2'b00} : 32'd0;
  assign bus_be        = in_req ? align_be : 4'd0;
  assign bus_wdata     = in_req ? align_wdata : 32'd0;
  assign done          = !reset && (state_reg == DONE);
  assign bus_err       = done && bus_err_reg;
  assign load_data     = reset ? 32'd0 : load_data_reg;
  assign stall         = !reset && core_req && (state_reg != DONE);

endmodule
